dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder: MEM-stage load/store responder over a word-organised synchronous RAM.
// Latency: stall_o high for 1+WAIT_STATES cycles per legal access; load data valid the cycle stall_o drops.
// Backpressure: stall_o holds the pipeline during an access; rejected requests answer in one cycle, no stall.
// Optional feature macro: DMEM_PERF_CNT_EN adds ld_count_o/st_count_o completion counters.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misaligned_o,
    output logic        err_o
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] ld_count_o,
    output logic [31:0] st_count_o
`endif
);

    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // funct3 encodings shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    // request captured at accept so the pipeline inputs may change afterwards
    logic [IDX_W-1:0]  cap_idx_q;
    logic [1:0]        cap_off_q;
    logic [2:0]        cap_f3_q;
    logic [31:0]       cap_wdata_q;
    logic              cap_we_q;

    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [31:0]       rdata_q;

    // request decode
    logic              req;
    logic              req_err;
    logic              req_mis;

    // FSM outputs
    logic              accept;
    logic              access;
    logic              stall;
    logic              err_p;
    logic              mis_p;
    logic              valid_p;

    // access operands: live inputs on a zero-wait accept, captured copy otherwise
    logic [IDX_W-1:0]  acc_idx;
    logic [1:0]        acc_off;
    logic [2:0]        acc_f3;
    logic [31:0]       acc_wdata;
    logic              acc_we;

    logic [3:0]        wr_be;
    logic [31:0]       wr_lanes;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       ld_ext;

    // address bits above the RAM index alias onto the same words
    logic              unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:IDX_W+2];

    assign req = mem_read_i | mem_write_i;

    // legality and alignment of the presented request; illegality outranks misalignment
    always_comb begin
        req_err = 1'b0;
        req_mis = 1'b0;
        if (mem_read_i && mem_write_i) begin
            req_err = 1'b1;
        end else if (mem_read_i) begin
            req_err = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end else if (mem_write_i) begin
            req_err = !(funct3_i inside {F3_B, F3_H, F3_W});
        end
        if (funct3_i[1:0] == 2'b01) begin
            req_mis = addr_i[0];
        end else if (funct3_i[1:0] == 2'b10) begin
            req_mis = (addr_i[1:0] != 2'b00);
        end
        if (req_err) begin
            req_mis = 1'b0;
        end
    end

    // next-state, wait counter and per-cycle handshake outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        stall   = 1'b0;
        err_p   = 1'b0;
        mis_p   = 1'b0;
        valid_p = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_err) begin
                        err_p = 1'b1;
                    end else if (req_mis) begin
                        mis_p = 1'b1;
                    end else begin
                        accept = 1'b1;
                        stall  = 1'b1;
                        cnt_d  = WAIT_LD;
                        if (WAIT_LD == 4'd0) begin
                            access  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                // a zero count here cannot occur normally; finish rather than hang
                if (cnt_q <= 4'd1) begin
                    access  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_p = !cap_we_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // select access operands
    always_comb begin
        acc_idx   = cap_idx_q;
        acc_off   = cap_off_q;
        acc_f3    = cap_f3_q;
        acc_wdata = cap_wdata_q;
        acc_we    = cap_we_q;
        if (state_q == ST_IDLE) begin
            acc_idx   = addr_i[IDX_W+1:2];
            acc_off   = addr_i[1:0];
            acc_f3    = funct3_i;
            acc_wdata = wdata_i;
            acc_we    = mem_write_i;
        end
    end

    // store byte enables and lane replication
    always_comb begin
        wr_be    = 4'b1111;
        wr_lanes = acc_wdata;
        case (acc_f3[1:0])
            2'b00: begin
                wr_be    = 4'b0001 << acc_off;
                wr_lanes = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                wr_be    = acc_off[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{acc_wdata[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = acc_wdata;
            end
        endcase
    end

    // load lane select and extension
    always_comb begin
        rd_word = mem_q[acc_idx];
        rd_byte = rd_word[{acc_off, 3'b000} +: 8];
        rd_half = rd_word[{acc_off[1], 4'b0000} +: 16];
        case (acc_f3)
            F3_B:    ld_ext = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    ld_ext = {{16{rd_half[15]}}, rd_half};
            F3_BU:   ld_ext = {24'd0, rd_byte};
            F3_HU:   ld_ext = {16'd0, rd_half};
            default: ld_ext = rd_word;
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // capture the accepted request
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cap_idx_q   <= '0;
            cap_off_q   <= 2'd0;
            cap_f3_q    <= 3'd0;
            cap_wdata_q <= 32'd0;
            cap_we_q    <= 1'b0;
        end else if (accept) begin
            cap_idx_q   <= addr_i[IDX_W+1:2];
            cap_off_q   <= addr_i[1:0];
            cap_f3_q    <= funct3_i;
            cap_wdata_q <= wdata_i;
            cap_we_q    <= mem_write_i;
        end
    end

    // RAM write port; contents survive reset but a store landing on a reset edge is dropped
    always_ff @(posedge clk_i) begin
        if (rst_ni && access && acc_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    // load result register, held until the next load completes
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= 32'd0;
        end else if (access && !acc_we) begin
            rdata_q <= ld_ext;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] ld_cnt_q;
    logic [31:0] st_cnt_q;

    // count completed accesses in their DONE cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ld_cnt_q <= 32'd0;
            st_cnt_q <= 32'd0;
        end else if (state_q == ST_DONE) begin
            if (cap_we_q) begin
                st_cnt_q <= st_cnt_q + 32'd1;
            end else begin
                ld_cnt_q <= ld_cnt_q + 32'd1;
            end
        end
    end

    assign ld_count_o = ld_cnt_q;
    assign st_count_o = st_cnt_q;
`endif

    // every output reads as zero while reset is held
    assign stall_o       = rst_ni & stall;
    assign err_o         = rst_ni & err_p;
    assign misaligned_o  = rst_ni & mis_p;
    assign rdata_valid_o = rst_ni & valid_p;
    assign rdata_o       = rst_ni ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WS    = 1;
    localparam int BYTES = DEPTH * 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [2:0]  funct3_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        misaligned_o;
    logic        err_o;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] ld_count_o;
    logic [31:0] st_count_o;
`endif

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .addr_i        (addr_i),
        .funct3_i      (funct3_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .misaligned_o  (misaligned_o),
        .err_o         (err_o)
`ifdef DMEM_PERF_CNT_EN
        ,
        .ld_count_o    (ld_count_o),
        .st_count_o    (st_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // reference: byte-addressed memory image plus the last completed load value
    logic [7:0]  mb [BYTES];
    logic [31:0] last_load = 32'd0;
    int          exp_ld_cnt = 0;
    int          exp_st_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // 0 = legal, 1 = illegal, 2 = misaligned
    function automatic int classify(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3);
        int size;
        if (rd && wr) return 1;
        if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1;
        if (wr && f3 > 3'd2) return 1;
        size = 1 << f3[1:0];
        if ((a % size) != 0) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int base;
        int size;
        logic [31:0] v;
        base = a % BYTES;
        size = 1 << f3[1:0];
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(mb[base + i]) << (8 * i));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        int base;
        int size;
        base = a % BYTES;
        size = 1 << f3[1:0];
        for (int i = 0; i < size; i++) mb[base + i] = wd[8*i +: 8];
    endtask

    // present one request and observe a bounded window of cycles (cycle 0 = presentation)
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] wd, output int nst, output int ner, output int nmis,
                           output int nval, output int vcyc, output logic [31:0] vdat);
        bit hold;
        nst = 0; ner = 0; nmis = 0; nval = 0; vcyc = -1; vdat = 32'd0;
        hold = 1'b1;
        mem_read_i = rd; mem_write_i = wr; addr_i = a; funct3_i = f3; wdata_i = wd;
        for (int c = 0; c < WS + 5; c++) begin
            @(negedge clk_i);
            if (stall_o)       nst++;
            if (err_o)         ner++;
            if (misaligned_o)  nmis++;
            if (rdata_valid_o) begin
                nval++;
                vcyc = c;
                vdat = rdata_o;
            end
            if (!stall_o) hold = 1'b0;
            @(posedge clk_i); #1;
            if (!hold) begin
                mem_read_i = 1'b0;
                mem_write_i = 1'b0;
            end
        end
        mem_read_i = 1'b0;
        mem_write_i = 1'b0;
    endtask

    task automatic do_req(input string name, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [2:0] f3, input logic [31:0] wd, input int kind, input logic [31:0] exp_data);
        int nst, ner, nmis, nval, vcyc;
        logic [31:0] vdat;
        bit is_load;
        run_req(rd, wr, a, f3, wd, nst, ner, nmis, nval, vcyc, vdat);
        is_load = (kind == 0) && rd;
        check({name, " stall cycles"}, 32'(nst), (kind == 0) ? 32'(1 + WS) : 32'd0);
        check({name, " err pulses"}, 32'(ner), (kind == 1) ? 32'd1 : 32'd0);
        check({name, " misaligned pulses"}, 32'(nmis), (kind == 2) ? 32'd1 : 32'd0);
        check({name, " valid pulses"}, 32'(nval), is_load ? 32'd1 : 32'd0);
        if (is_load) begin
            check({name, " valid cycle"}, 32'(vcyc), 32'(1 + WS));
            check({name, " rdata"}, vdat, exp_data);
            last_load = exp_data;
            exp_ld_cnt++;
        end
        if (kind == 0 && wr) begin
            model_store(a, f3, wd);
            exp_st_cnt++;
        end
        check({name, " rdata hold"}, rdata_o, last_load);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [2:0]  f3;
        logic [31:0] wd;
        int          kind;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        rd, wr;
        logic [31:0] a, wd, ed;
        logic [2:0]  f3;
        int          k, r;

        tbl[0]  = '{1'b0, 1'b1, 32'h10,   3'd2, 32'hDEADBEEF, 0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,   3'd2, 32'h0,        0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'h20,   3'd2, 32'h00000000, 0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h22,   3'd0, 32'h00000080, 0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h22,   3'd0, 32'h0,        0, 32'hFFFFFF80};
        tbl[5]  = '{1'b1, 1'b0, 32'h22,   3'd4, 32'h0,        0, 32'h00000080};
        tbl[6]  = '{1'b1, 1'b0, 32'h20,   3'd2, 32'h0,        0, 32'h00800000};
        tbl[7]  = '{1'b0, 1'b1, 32'h30,   3'd2, 32'h13572468, 0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 32'h31,   3'd1, 32'h0000FFFF, 2, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h30,   3'd2, 32'h0,        0, 32'h13572468};
        tbl[10] = '{1'b1, 1'b0, 32'h32,   3'd2, 32'h0,        2, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 32'h10,   3'd2, 32'h0,        1, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h10,   3'd3, 32'h0,        1, 32'h0};
        tbl[13] = '{1'b0, 1'b1, 32'h10,   3'd4, 32'h0,        1, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 32'h01,   3'd7, 32'h0,        1, 32'h0};
        tbl[15] = '{1'b0, 1'b1, 32'h1000, 3'd2, 32'h12345678, 0, 32'h0};
        tbl[16] = '{1'b1, 1'b0, 32'h0,    3'd2, 32'h0,        0, 32'h12345678};
        tbl[17] = '{1'b1, 1'b0, 32'h2,    3'd1, 32'h0,        0, 32'h00001234};
        tbl[18] = '{1'b0, 1'b1, 32'h4,    3'd2, 32'h00000000, 0, 32'h0};
        tbl[19] = '{1'b0, 1'b1, 32'h6,    3'd1, 32'h55558001, 0, 32'h0};
        tbl[20] = '{1'b0, 1'b1, 32'h5,    3'd0, 32'hABCDEF7F, 0, 32'h0};
        tbl[21] = '{1'b1, 1'b0, 32'h6,    3'd1, 32'h0,        0, 32'hFFFF8001};
        tbl[22] = '{1'b1, 1'b0, 32'h6,    3'd5, 32'h0,        0, 32'h00008001};
        tbl[23] = '{1'b1, 1'b0, 32'h4,    3'd2, 32'h0,        0, 32'h80017F00};
        tbl[24] = '{1'b1, 1'b0, 32'h5,    3'd0, 32'h0,        0, 32'h0000007F};
        tbl[25] = '{1'b1, 1'b0, 32'h5,    3'd1, 32'h0,        2, 32'h0};
        tbl[26] = '{1'b0, 1'b1, 32'h3,    3'd3, 32'h0,        1, 32'h0};
        tbl[27] = '{1'b0, 1'b1, 32'h40,   3'd2, 32'h11111111, 0, 32'h0};

        rst_ni = 1'b0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; addr_i = 32'd0; funct3_i = 3'd0; wdata_i = 32'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset stall_o", {31'd0, stall_o}, 32'd0);
        check("reset rdata_valid_o", {31'd0, rdata_valid_o}, 32'd0);
        check("reset err_o", {31'd0, err_o}, 32'd0);
        check("reset misaligned_o", {31'd0, misaligned_o}, 32'd0);
        check("reset rdata_o", rdata_o, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < NV; i++) begin
            do_req($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].f3,
                   tbl[i].wd, tbl[i].kind, tbl[i].exp);
        end

        // reset lands in the WAIT cycle of a store, request still presented
        mem_read_i = 1'b0; mem_write_i = 1'b1; addr_i = 32'h40; funct3_i = 3'd2; wdata_i = 32'hAAAAAAAA;
        @(negedge clk_i);
        check("rstseq accept stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            check($sformatf("rstseq%0d stall_o", c), {31'd0, stall_o}, 32'd0);
            check($sformatf("rstseq%0d rdata_o", c), rdata_o, 32'd0);
            check($sformatf("rstseq%0d pulses", c), {29'd0, rdata_valid_o, err_o, misaligned_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        mem_write_i = 1'b0;
        rst_ni = 1'b1;
        last_load = 32'd0;
        exp_ld_cnt = 0;
        exp_st_cnt = 0;
        check("post reset rdata_o", rdata_o, 32'd0);
        do_req("rstseq reload", 1'b1, 1'b0, 32'h40, 3'd2, 32'h0, 0, 32'h11111111);

        // prefill a region so random loads only touch written bytes
        for (int w = 0; w < 32; w++) begin
            do_req($sformatf("fill%0d", w), 1'b0, 1'b1, 32'h100 + 32'(4 * w), 3'd2, $urandom, 0, 32'h0);
        end

        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 19);
            rd = (r <= 10);
            wr = (r == 0) || (r > 10);
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFFF000) | 32'h100 | 32'($urandom_range(0, 127));
            wd = $urandom;
            k  = classify(rd, wr, a, f3);
            ed = (k == 0 && rd) ? model_load(a, f3) : 32'h0;
            do_req($sformatf("rnd%0d", i), rd, wr, a, f3, wd, k, ed);
        end

`ifdef DMEM_PERF_CNT_EN
        check("ld_count_o", ld_count_o, 32'(exp_ld_cnt));
        check("st_count_o", st_count_o, 32'(exp_st_cnt));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
